pwm_scan_ctrl: RTL and testbench
================================

Name: pwm_scan_ctrl

Overview:
- Timing and data source that sits directly upstream of the per-channel PWM comparators.
- Accepts channel duty words over a valid/ready stream into a shadow buffer.
- Generates the shared free-running `count` ramp and the one-cycle `hsync` line-start strobe.
- Presents a stable, double-buffered duty word per channel, so every PWM sees new data latched on the `hsync` rising edge.

Parameters:
- DWIDTH, 8: width of duty words and of `count`. Period is 2^DWIDTH cycles; MAX = 2^DWIDTH-1.
- NCH, 4: number of PWM channels fed (≥1).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low holds the ramp at 0.
- in_valid  input  1  upstream duty word valid.
- in_data  input  DWIDTH  duty word; channel order 0..NCH-1.
- in_ready  output  1  shadow buffer can accept a word.
- count  output  DWIDTH  shared PWM ramp.
- hsync  output  1  line-start strobe, high exactly while `count`==0.
- ch_data  output  NCH*DWIDTH  active duty words; channel k in bits [k*DWIDTH +: DWIDTH].
- line_done  output  1  one-cycle pulse: shadow copied to active.
- underrun  output  1  sticky: a swap point passed with shadow not full.
- clr_underrun  input  1  synchronous clear of `underrun`.

Behaviour:
- Reset values (async, immediate): count=0, hsync=0, ch_data=0, line_done=0, underrun=0, fill index=0, shadow=0, in_ready=1.
- All outputs are registered; no combinational path from inputs to outputs except `in_ready`, which is a function of the fill index only.

Ramp:
- en=1: `count` increments by 1 each cycle and wraps MAX→0.
- en=0: `count` is forced to 0 at the next edge and held; `hsync`=0; shadow, fill index and `ch_data` are retained.
- hsync=1 iff en was high at the edge that produced count==0, i.e. asserted in every cycle with count==0 while running, including the first cycle after `en` rises.

Stream input:
- A word is accepted on an edge with in_valid && in_ready. It is written to shadow[fill], then fill increments.
- in_ready = (fill < NCH).

Swap point: the edge where `count` goes MAX-1→MAX with en=1.
- Shadow full (fill==NCH, evaluated before the edge): ch_data <= shadow, fill <= 0, line_done=1 for the cycle with count==MAX.
- Shadow not full: ch_data unchanged (line repeats), underrun <= 1, fill/shadow untouched; filling continues.
- Result: ch_data is stable for the full cycle before `hsync` rises and for the whole following period.
- Corner case: a word completing the buffer on the swap edge itself does not count for that swap; it is used at the next swap.

Other boundaries:
- clr_underrun and an underrun event on the same edge: set wins.
- DWIDTH=1: swap edge is count 0→1.
- rst mid-period: all state returns to reset values immediately; the first hsync comes in the first count==0 cycle with en high after rst is released.

Test Plan (DWIDTH=4, NCH=2, MAX=15):
- Reset then en=1, no input → count cycles 0..15, hsync high only at count=0 (every 16 cycles); underrun=1 after first count 14→15 edge; ch_data=0.
- Send 0x3 then 0xA → in_ready drops after second word; at next 14→15 edge ch_data={0xA,0x3}, line_done pulses 1 cycle at count=15, in_ready=1 next cycle, hsync high on following cycle.
- Send one word only, let swap point pass → ch_data unchanged, underrun=1; send second word, next swap loads both; clr_underrun → underrun=0.
- Complete buffer on exact swap edge (second word accepted at count 14→15) → no swap that period; swap occurs 16 cycles later.
- Drop en at count=7 → count=0, hsync=0 held; re-raise en → hsync high first cycle, count resumes 1,2,…
- Assert rst at count=9 with shadow half full → all outputs reset immediately, in_ready=1, previous shadow word lost.

Source files
------------

// File: rtl/pwm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_scan_ctrl
//
// Purpose:
//   Timing and data source for a bank of per-channel PWM comparators.
//   It generates the shared free-running ramp `count` and the one-cycle
//   line-start strobe `hsync`. It also collects duty words from a
//   valid/ready stream into a shadow buffer. At a fixed point in each
//   period, the buffer is copied into the active duty registers `ch_data`,
//   so every channel sees new data at the same ramp position.
//
// Parameters:
//   DWIDTH : width of duty words and of the ramp (period = 2**DWIDTH cycles)
//   NCH    : number of PWM channels fed (>= 1)
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst          in   asynchronous active-high reset
//   en           in   scan enable; low forces and holds the ramp at 0
//   in_valid     in   upstream duty word valid
//   in_data      in   duty word, channels delivered in order 0..NCH-1
//   in_ready     out  shadow buffer has room (depends on fill index only)
//   count        out  shared PWM ramp
//   hsync        out  high exactly in the running cycles where count == 0
//   ch_data      out  active duty words, channel k at [k*DWIDTH +: DWIDTH]
//   line_done    out  one-cycle pulse when shadow was copied to active
//   underrun     out  sticky flag: a swap point passed with shadow not full
//   clr_underrun in   synchronous clear of underrun (a new event wins)
// ---------------------------------------------------------------------------
module pwm_scan_ctrl #(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [DWIDTH-1:0]       in_data,
  output logic                    in_ready,
  output logic [DWIDTH-1:0]       count,
  output logic                    hsync,
  output logic [NCH*DWIDTH-1:0]   ch_data,
  output logic                    line_done,
  output logic                    underrun,
  input  logic                    clr_underrun
);

  // The fill index must be able to hold NCH itself ("buffer full").
  localparam int                FW        = $clog2(NCH + 1);
  localparam logic [FW-1:0]     FILL_FULL = FW'(NCH);
  localparam logic [DWIDTH-1:0] CNT_MAX   = '1;
  // The copy happens on the edge that moves the ramp from MAX-1 to MAX.
  // This gives the active words a full cycle to settle before hsync.
  localparam logic [DWIDTH-1:0] CNT_SWAP  = CNT_MAX - DWIDTH'(1);

  // The scan FSM records whether the previous edge saw en high.
  // The first enabled edge after idle restarts the line at count 0 with
  // hsync high, instead of advancing the ramp.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } scanState_t;

  scanState_t                r_state;
  scanState_t                w_stateNext;
  logic                      w_restart;
  logic                      w_advance;

  logic [DWIDTH-1:0]         r_count;
  logic                      r_hsync;
  logic [FW-1:0]             r_fill;
  logic [NCH*DWIDTH-1:0]     r_shadow;
  logic [NCH*DWIDTH-1:0]     r_chData;
  logic                      r_lineDone;
  logic                      r_underrun;

  logic                      w_accept;
  logic                      w_full;
  logic                      w_swap;

  // ---------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // ---------------------------------------------------------------------
  // Scan FSM: next state. The FSM runs whenever enable is high.
  // ---------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_stateNext = S_RUN;
      S_RUN:   if (!en) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Scan FSM: outputs.
  //   w_restart : the ramp begins a fresh line at 0.
  //   w_advance : the ramp steps forward normally.
  // ---------------------------------------------------------------------
  always_comb begin
    w_restart = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE:  w_restart = en;
      S_RUN:   w_advance = en;
      default: begin
        w_restart = 1'b0;
        w_advance = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Ramp and line-start strobe.
  // hsync is registered alongside count, so it is high exactly in the
  // cycles where a running ramp shows 0. This includes the restart cycle
  // after enable rises.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_hsync <= 1'b0;
    end else if (!en) begin
      r_count <= '0;
      r_hsync <= 1'b0;
    end else if (w_restart) begin
      r_count <= '0;
      r_hsync <= 1'b1;
    end else begin
      r_count <= r_count + DWIDTH'(1);
      r_hsync <= (r_count == CNT_MAX);
    end
  end

  // Stream handshake and swap decision.
  // w_full is sampled before the edge, so a word that completes the
  // buffer on the swap edge itself is held for the following swap.
  assign in_ready = (r_fill < FILL_FULL);
  assign w_accept = in_valid && in_ready;
  assign w_full   = (r_fill == FILL_FULL);
  assign w_swap   = w_advance && (r_count == CNT_SWAP);

  // ---------------------------------------------------------------------
  // Fill index. A successful swap empties the buffer. Otherwise each
  // accepted word bumps the index. The two cannot coincide, because a
  // full buffer deasserts in_ready.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= '0;
    end else if (w_swap && w_full) begin
      r_fill <= '0;
    end else if (w_accept) begin
      r_fill <= r_fill + FW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Shadow buffer. Each accepted word lands in the slot named by the fill
  // index, so channel order follows stream order.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_accept && (r_fill == FW'(k))) begin
          r_shadow[k*DWIDTH +: DWIDTH] <= in_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Active duty words and line-done pulse. If the shadow is not full at
  // the swap point, the previous line is simply repeated.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chData   <= '0;
      r_lineDone <= 1'b0;
    end else begin
      r_lineDone <= w_swap && w_full;
      if (w_swap && w_full) begin
        r_chData <= r_shadow;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky underrun flag. A new underrun event takes priority over a
  // clear on the same edge, so that no event is ever lost.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_swap && !w_full) begin
      r_underrun <= 1'b1;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign count     = r_count;
  assign hsync     = r_hsync;
  assign ch_data   = r_chData;
  assign line_done = r_lineDone;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_scan_ctrl
//
// Directed bench for pwm_scan_ctrl with DWIDTH=4, NCH=2 (MAX=15).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pwm_scan_ctrl;

  localparam int DWIDTH = 4;
  localparam int NCH    = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  in_valid;
  logic [DWIDTH-1:0]     in_data;
  logic                  in_ready;
  logic [DWIDTH-1:0]     count;
  logic                  hsync;
  logic [NCH*DWIDTH-1:0] ch_data;
  logic                  line_done;
  logic                  underrun;
  logic                  clr_underrun;

  int nChecks = 0;
  int nErrors = 0;

  pwm_scan_ctrl #(.DWIDTH(DWIDTH), .NCH(NCH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .count        (count),
    .hsync        (hsync),
    .ch_data      (ch_data),
    .line_done    (line_done),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n falling edges.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step until the ramp shows target, bounded. A timeout is a failed check.
  task automatic waitCount(input logic [DWIDTH-1:0] target);
    int n;
    n = 0;
    while (count !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    assert (n < 40)
    else begin
      nErrors++;
      $error("[TB] FAIL waitCount: observed=%0h expected=%0h", count, target);
    end
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    clr_underrun = 1'b0;

    // ---- Reset values ----
    #1;
    checkOutput("rst_count",     count,     0);
    checkOutput("rst_hsync",     hsync,     0);
    checkOutput("rst_ch_data",   ch_data,   0);
    checkOutput("rst_line_done", line_done, 0);
    checkOutput("rst_underrun",  underrun,  0);
    checkOutput("rst_in_ready",  in_ready,  1);

    // ---- Free run with no input ----
    applyStimulus(1);
    rst = 1'b0;
    en  = 1'b1;
    applyStimulus(1);
    checkOutput("run_first_count", count, 0);
    checkOutput("run_first_hsync", hsync, 1);
    applyStimulus(1);
    checkOutput("run_c1_count", count, 1);
    checkOutput("run_c1_hsync", hsync, 0);
    waitCount(4'd14);
    checkOutput("run_c14_underrun", underrun, 0);
    applyStimulus(1);
    checkOutput("run_c15_count",    count,     15);
    checkOutput("run_c15_underrun", underrun,  1);
    checkOutput("run_c15_line_done", line_done, 0);
    applyStimulus(1);
    checkOutput("run_wrap_count",   count,   0);
    checkOutput("run_wrap_hsync",   hsync,   1);
    checkOutput("run_wrap_ch_data", ch_data, 0);

    // ---- Load 0x3, 0xA, then swap ----
    in_valid = 1'b1;
    in_data  = 4'h3;
    applyStimulus(1);
    checkOutput("load_ready_after1", in_ready, 1);
    in_data = 4'hA;
    applyStimulus(1);
    checkOutput("load_ready_after2", in_ready, 0);
    in_valid = 1'b0;
    waitCount(4'd14);
    checkOutput("load_c14_ch_data", ch_data, 8'h00);
    applyStimulus(1);
    checkOutput("load_c15_ch_data",   ch_data,   8'hA3);
    checkOutput("load_c15_line_done", line_done, 1);
    checkOutput("load_c15_in_ready",  in_ready,  1);
    applyStimulus(1);
    checkOutput("load_c0_hsync",     hsync,     1);
    checkOutput("load_c0_line_done", line_done, 0);
    checkOutput("load_c0_underrun",  underrun,  1);
    clr_underrun = 1'b1;
    applyStimulus(1);
    clr_underrun = 1'b0;
    checkOutput("clr_underrun", underrun, 0);

    // ---- One word only: the line repeats and underrun is flagged ----
    in_valid = 1'b1;
    in_data  = 4'h5;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("half_in_ready", in_ready, 1);
    waitCount(4'd15);
    checkOutput("half_c15_ch_data",   ch_data,   8'hA3);
    checkOutput("half_c15_underrun",  underrun,  1);
    checkOutput("half_c15_line_done", line_done, 0);
    in_valid = 1'b1;
    in_data  = 4'h6;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("half_full_ready", in_ready, 0);
    waitCount(4'd15);
    checkOutput("half_swap_ch_data",   ch_data,   8'h65);
    checkOutput("half_swap_line_done", line_done, 1);
    applyStimulus(1);
    clr_underrun = 1'b1;
    applyStimulus(1);
    clr_underrun = 1'b0;
    checkOutput("half_clr_underrun", underrun, 0);

    // ---- Buffer completes on the swap edge itself ----
    in_valid = 1'b1;
    in_data  = 4'h7;
    applyStimulus(1);
    in_valid = 1'b0;
    waitCount(4'd14);
    in_valid = 1'b1;
    in_data  = 4'h9;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("edge_c15_ch_data",   ch_data,   8'h65);
    checkOutput("edge_c15_line_done", line_done, 0);
    checkOutput("edge_c15_underrun",  underrun,  1);
    checkOutput("edge_c15_in_ready",  in_ready,  0);
    applyStimulus(1);
    waitCount(4'd15);
    checkOutput("edge_next_ch_data",   ch_data,   8'h97);
    checkOutput("edge_next_line_done", line_done, 1);
    applyStimulus(1);

    // ---- Enable dropped at count 7 ----
    waitCount(4'd7);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("en_off_count",   count,   0);
    checkOutput("en_off_hsync",   hsync,   0);
    applyStimulus(3);
    checkOutput("en_hold_count",   count,   0);
    checkOutput("en_hold_hsync",   hsync,   0);
    checkOutput("en_hold_ch_data", ch_data, 8'h97);
    en = 1'b1;
    applyStimulus(1);
    checkOutput("en_on_count", count, 0);
    checkOutput("en_on_hsync", hsync, 1);
    applyStimulus(1);
    checkOutput("en_on_c1", count, 1);
    applyStimulus(1);
    checkOutput("en_on_c2", count, 2);

    // ---- Reset at count 9 with the shadow half full ----
    in_valid = 1'b1;
    in_data  = 4'hC;
    applyStimulus(1);
    in_valid = 1'b0;
    waitCount(4'd9);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_count",     count,     0);
    checkOutput("mid_rst_hsync",     hsync,     0);
    checkOutput("mid_rst_ch_data",   ch_data,   0);
    checkOutput("mid_rst_underrun",  underrun,  0);
    checkOutput("mid_rst_line_done", line_done, 0);
    checkOutput("mid_rst_in_ready",  in_ready,  1);
    applyStimulus(1);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hD;
    applyStimulus(1);
    checkOutput("post_rst_count", count, 0);
    checkOutput("post_rst_hsync", hsync, 1);
    in_data = 4'hE;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("post_rst_in_ready", in_ready, 0);
    waitCount(4'd15);
    checkOutput("post_rst_ch_data",   ch_data,   8'hED);
    checkOutput("post_rst_line_done", line_done, 1);
    checkOutput("post_rst_underrun",  underrun,  0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
